// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: sequencer state encoding and width helper for pll_reset_ctrl
package pll_rst_pkg;
  typedef enum logic [2:0] {RST_PLL, WAIT_LOCK, STABLE, RUN, STANDBY, FAIL} state_e;
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit two-flop synchronizer, async active-low reset to 0
//   clk   - destination clock
//   rst_n - async active-low reset
//   d_i   - asynchronous input
//   q_o   - synchronized output
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl: PLL reset/lock sequencer with timed release, retry and sticky failure
//   refclk    - 24 MHz reference clock
//   reset_n   - async active-low reset
//   extlock   - PLL lock, asynchronous
//   stdby_req - standby request (honoured only in RUN)
//   pll_reset - PLL reset, pll_stdby - PLL standby
//   sys_rst_n - system reset release, locked - synchronized lock
//   lock_err  - sticky failure, retry_cnt - consecutive lock timeouts
module pll_reset_ctrl
  import pll_rst_pkg::*;
#(
  parameter int RST_CYCLES    = 24,
  parameter int LOCK_TIMEOUT  = 24000,
  parameter int STABLE_CYCLES = 240,
  parameter int MAX_RETRY     = 3
) (
  input  logic                           refclk,
  input  logic                           reset_n,
  input  logic                           extlock,
  input  logic                           stdby_req,
  output logic                           pll_reset,
  output logic                           pll_stdby,
  output logic                           sys_rst_n,
  output logic                           locked,
  output logic                           lock_err,
  output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt
);
  localparam int CW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d, retry_inc;
  logic armed_q, lock_s;
  logic pll_reset_q, pll_stdby_q, sys_rst_n_q, lock_err_q;
  sync_2ff u_lock_sync (.clk(refclk), .rst_n(reset_n), .d_i(extlock), .q_o(lock_s));
  // The first edge after reset release only arms the sequencer, so the PLL
  // reset is held through edges 0..RST_CYCLES-1 of the released clock.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    retry_inc = retry_q + RW'(1);
    if (armed_q)
      case (state_q)
        RST_PLL:   if (cnt_q == CW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
        WAIT_LOCK:
          if (lock_s) state_d = STABLE;
          else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
            retry_d = retry_inc;
            state_d = (retry_inc == RW'(MAX_RETRY)) ? FAIL : RST_PLL;
          end
        STABLE:
          if (!lock_s) state_d = WAIT_LOCK;
          else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
            state_d = RUN;
            retry_d = '0;
          end
        RUN:       state_d = !lock_s ? RST_PLL : stdby_req ? STANDBY : RUN;
        STANDBY:   state_d = stdby_req ? STANDBY : RST_PLL;
        default:   state_d = state_q;
      endcase
    cnt_d = !armed_q ? cnt_q
          : (state_d != state_q || state_q inside {RUN, STANDBY, FAIL}) ? '0
          : cnt_q + CW'(1);
  end
  always_ff @(posedge refclk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= RST_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      armed_q     <= 1'b0;
      pll_reset_q <= 1'b1;
      pll_stdby_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      lock_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      armed_q     <= 1'b1;
      pll_reset_q <= state_d inside {RST_PLL, FAIL};
      pll_stdby_q <= state_d == STANDBY;
      sys_rst_n_q <= state_d == RUN;
      lock_err_q  <= state_d == FAIL;
    end
  assign pll_reset = pll_reset_q;
  assign pll_stdby = pll_stdby_q;
  assign sys_rst_n = sys_rst_n_q;
  assign lock_err  = lock_err_q;
  assign locked    = lock_s;
  assign retry_cnt = retry_q;
endmodule

// File: tb/tb_pll_reset_ctrl.sv
// tb_pll_reset_ctrl: vector table, corner sequences and random run against a timestamp model
module tb_pll_reset_ctrl;
  localparam int RSTC = 4, TO = 16, STB = 8, MAXR = 3;
  localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3, P_SBY = 4, P_FAIL = 5;
  logic refclk = 0, reset_n = 1, extlock = 0, stdby_req = 0;
  logic pll_reset, pll_stdby, sys_rst_n, locked, lock_err;
  logic [1:0] retry_cnt;
  int pass_cnt = 0, chk_cnt = 0;
  int m_ph, m_dl, m_retry, m_n;
  bit hist[$];
  typedef struct {int cyc; bit ext; bit sby; logic [6:0] exp;} vec_t;
  vec_t tbl[19];

  pll_reset_ctrl #(.RST_CYCLES(RSTC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(STB), .MAX_RETRY(MAXR)) dut (
    .refclk(refclk), .reset_n(reset_n), .extlock(extlock), .stdby_req(stdby_req),
    .pll_reset(pll_reset), .pll_stdby(pll_stdby), .sys_rst_n(sys_rst_n),
    .locked(locked), .lock_err(lock_err), .retry_cnt(retry_cnt));

  always #5 refclk = ~refclk;

  function automatic logic [6:0] outs();
    return {pll_reset, pll_stdby, sys_rst_n, locked, lock_err, retry_cnt};
  endfunction

  // Outputs are a pure function of the phase; locked lags the extlock sample by one edge.
  function automatic logic [6:0] model_outs();
    bit lk;
    lk = (m_n >= 2) ? hist[m_n-2] : 1'b0;
    return {1'(m_ph == P_RST || m_ph == P_FAIL), 1'(m_ph == P_SBY), 1'(m_ph == P_RUN),
            lk, 1'(m_ph == P_FAIL), 2'(m_retry)};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Each phase carries an absolute deadline edge; the FSM sees extlock as sampled two edges earlier.
  task automatic model_edge();
    bit lk;
    lk = (m_n >= 2) ? hist[m_n-2] : 1'b0;
    hist.push_back(extlock);
    case (m_ph)
      P_RST:  if (m_n == m_dl) begin m_ph = P_WAIT; m_dl = m_n + TO; end
      P_WAIT: if (lk) begin m_ph = P_STB; m_dl = m_n + STB; end
              else if (m_n == m_dl) begin
                m_retry++;
                m_ph = (m_retry == MAXR) ? P_FAIL : P_RST;
                m_dl = m_n + RSTC;
              end
      P_STB:  if (!lk) begin m_ph = P_WAIT; m_dl = m_n + TO; end
              else if (m_n == m_dl) begin m_ph = P_RUN; m_retry = 0; end
      P_RUN:  if (!lk) begin m_ph = P_RST; m_dl = m_n + RSTC; end
              else if (stdby_req) m_ph = P_SBY;
      P_SBY:  if (!stdby_req) begin m_ph = P_RST; m_dl = m_n + RSTC; end
      default: ;
    endcase
    m_n++;
  endtask

  task automatic step();
    @(posedge refclk);
    model_edge();
    #1;
    check("model", outs(), model_outs());
  endtask

  task automatic do_reset();
    reset_n = 0;
    #1;
    check("async_reset", outs(), 7'b1000000);
    m_ph = P_RST; m_dl = RSTC; m_retry = 0; m_n = 0;
    hist.delete();
    @(negedge refclk);
    reset_n = 1;
  endtask

  initial begin
    int fall[$], rise[$];
    logic prev;
    tbl[0]  = '{4, 0, 0, 7'b1000000};
    tbl[1]  = '{1, 0, 0, 7'b0000000};
    tbl[2]  = '{4, 0, 0, 7'b0000000};
    tbl[3]  = '{1, 1, 0, 7'b0000000};
    tbl[4]  = '{1, 1, 0, 7'b0001000};
    tbl[5]  = '{8, 1, 0, 7'b0001000};
    tbl[6]  = '{1, 1, 0, 7'b0011000};
    tbl[7]  = '{3, 1, 0, 7'b0011000};
    tbl[8]  = '{1, 1, 1, 7'b0101000};
    tbl[9]  = '{3, 0, 1, 7'b0100000};
    tbl[10] = '{1, 1, 0, 7'b1000000};
    tbl[11] = '{3, 1, 0, 7'b1001000};
    tbl[12] = '{1, 1, 0, 7'b0001000};
    tbl[13] = '{1, 1, 0, 7'b0001000};
    tbl[14] = '{8, 1, 0, 7'b0011000};
    tbl[15] = '{2, 0, 0, 7'b0010000};
    tbl[16] = '{1, 0, 1, 7'b1000000};
    tbl[17] = '{3, 0, 0, 7'b1000000};
    tbl[18] = '{1, 0, 0, 7'b0000000};
    #2;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      extlock = tbl[i].ext;
      stdby_req = tbl[i].sby;
      repeat (tbl[i].cyc) step();
      check($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    // no lock at all: three reset pulses, then sticky failure
    extlock = 0; stdby_req = 0;
    do_reset();
    prev = 1;
    for (int e = 0; e < 70; e++) begin
      step();
      if (prev && !pll_reset) fall.push_back(e);
      if (!prev && pll_reset) rise.push_back(e);
      prev = pll_reset;
      if (e == 20 || e == 40) check($sformatf("retry_at_%0d", e), retry_cnt, e / 20);
    end
    check("nolock_falls", fall.size(), 3);
    check("nolock_rises", rise.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("fall%0d", i), (i < fall.size()) ? fall[i] : -1, 4 + 20 * i);
      check($sformatf("rise%0d", i), (i < rise.size()) ? rise[i] : -1, 20 + 20 * i);
    end
    check("fail_state", outs(), 7'b1000111);
    extlock = 1; stdby_req = 1;
    repeat (20) step();
    check("fail_sticky", outs(), 7'b1001111);
    // lock glitch after 5 stable cycles
    extlock = 1; stdby_req = 0;
    do_reset();
    repeat (9) step();
    extlock = 0;
    repeat (2) step();
    extlock = 1;
    repeat (10) step();
    check("glitch_hold", outs(), 7'b0001000);
    step();
    check("glitch_release", outs(), 7'b0011000);
    // async reset in WAIT_LOCK after two timeouts
    extlock = 0;
    do_reset();
    repeat (48) step();
    check("wait_retry2", outs(), 7'b0000010);
    do_reset();
    // random run
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) extlock = ~extlock;
      if ($urandom_range(19) == 0) stdby_req = ~stdby_req;
      if ($urandom_range(799) == 0) do_reset();
      step();
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
